ext_irq_controller: RTL and testbench

- Parametrised platform-level external interrupt controller with NUM_SOURCES gated sources.
- Latches per-source pending state (level or edge mode) and arbitrates by programmable priority against a threshold.
- Drives a single registered meip line into the CSR mip[11] path.
- Software services interrupts through a claim/complete register handshake on a simple word-addressed register bus.

---
 rtl/ext_irq_controller.sv | 188 ++++++++++++++++++
 tb/tb_ext_irq_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_controller.sv
// ext_irq_controller
//   Platform-level external interrupt controller. Each source passes through a
//   gateway (level or edge mode) that latches a pending bit. Pending, enabled
//   sources whose priority exceeds the threshold are arbitrated: highest
//   priority wins and ties go to the lowest ID. The winner is registered onto
//   best_id and meip. Software services interrupts by reading the claim
//   register, which returns and claims the winner, and then writing the
//   serviced ID back to the same register to complete it.
//
//   Optional build macro EXT_IRQ_SYNC_EN: when defined, every irq_src bit
//   passes through a two-flop synchronizer before the gateway. This adds two
//   edges of source-to-meip latency.
//
// Ports
//   clk        core clock
//   rst        synchronous, active-low reset
//   irq_src    raw source lines; bit i-1 is source ID i
//   reg_we     register write strobe
//   reg_re     register read strobe
//   reg_addr   word address
//   reg_wdata  write data
//   reg_rdata  registered read data, held until the next read
//   meip       registered machine external interrupt request
//   best_id    registered current winning ID, 0 if none
//
// Register map (word addresses)
//   0x01..NUM_SOURCES  priority[i]
//   0x40               enable
//   0x41               pending (read-only)
//   0x42               threshold
//   0x43               claim (read) / complete (write)
//   0x44               edge_mode
module ext_irq_controller #(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   reg_we,
    input  logic                   reg_re,
    input  logic [ADDR_WIDTH-1:0]  reg_addr,
    input  logic [31:0]            reg_wdata,
    output logic [31:0]            reg_rdata,
    output logic                   meip,
    output logic [4:0]             best_id
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE    = ADDR_WIDTH'('h40);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING   = ADDR_WIDTH'('h41);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THRESHOLD = ADDR_WIDTH'('h42);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLAIM     = ADDR_WIDTH'('h43);
    localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE      = ADDR_WIDTH'('h44);

    // Per-source state is indexed by source ID (1..NUM_SOURCES).
    logic [NUM_SOURCES:1]  src;
    logic [NUM_SOURCES:1]  prev_src;
    logic [NUM_SOURCES:1]  enable;
    logic [NUM_SOURCES:1]  edge_mode;
    logic [NUM_SOURCES:1]  pending;
    logic [NUM_SOURCES:1]  in_service;
    logic [PRIO_WIDTH-1:0] prio [1:NUM_SOURCES];
    logic [PRIO_WIDTH-1:0] threshold;

    logic [4:0]            win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic [31:0]           rdata_next;
    logic                  rd_claim;
    logic                  wr_complete;
    logic                  unused_wdata;

    assign unused_wdata = ^reg_wdata;

`ifdef EXT_IRQ_SYNC_EN
    logic [NUM_SOURCES-1:0] sync_q1;
    logic [NUM_SOURCES-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_src;
`endif

    // Seeding win_prio with the threshold applies the "priority > threshold"
    // filter. The strict compare in an ascending scan keeps the lowest ID on ties.
    always_comb begin
        win_id   = '0;
        win_prio = threshold;
        for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
            if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
                win_id   = 5'(i);
                win_prio = prio[i];
            end
        end
    end

    assign rd_claim    = reg_re && (reg_addr == ADDR_CLAIM);
    assign wr_complete = reg_we && (reg_addr == ADDR_CLAIM);

    always_comb begin
        rdata_next = '0;
        for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
            if (reg_addr == ADDR_WIDTH'(i)) begin
                rdata_next[PRIO_WIDTH-1:0] = prio[i];
            end
        end
        if (reg_addr == ADDR_ENABLE) begin
            rdata_next[NUM_SOURCES:1] = enable;
        end else if (reg_addr == ADDR_PENDING) begin
            rdata_next[NUM_SOURCES:1] = pending;
        end else if (reg_addr == ADDR_THRESHOLD) begin
            rdata_next[PRIO_WIDTH-1:0] = threshold;
        end else if (reg_addr == ADDR_CLAIM) begin
            rdata_next[4:0] = win_id;
        end else if (reg_addr == ADDR_EDGE) begin
            rdata_next[NUM_SOURCES:1] = edge_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_src   <= '0;
            enable     <= '0;
            edge_mode  <= '0;
            pending    <= '0;
            in_service <= '0;
            threshold  <= '0;
            reg_rdata  <= '0;
            meip       <= 1'b0;
            best_id    <= '0;
            for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
                prio[i] <= '0;
            end
        end else begin
            prev_src <= src;
            best_id  <= win_id;
            meip     <= (win_id != '0);

            if (reg_re) begin
                reg_rdata <= rdata_next;
            end

            if (reg_we) begin
                for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
                    if (reg_addr == ADDR_WIDTH'(i)) begin
                        prio[i] <= reg_wdata[PRIO_WIDTH-1:0];
                    end
                end
                if (reg_addr == ADDR_ENABLE) begin
                    enable <= reg_wdata[NUM_SOURCES:1];
                end else if (reg_addr == ADDR_THRESHOLD) begin
                    threshold <= reg_wdata[PRIO_WIDTH-1:0];
                end else if (reg_addr == ADDR_EDGE) begin
                    edge_mode <= reg_wdata[NUM_SOURCES:1];
                end
            end

            // A claimed source cannot also be in service, so a claim and a
            // complete never target the same ID in one cycle. The claim
            // branch also suppresses any gateway request arriving alongside it.
            for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
                if (rd_claim && (win_id == 5'(i))) begin
                    pending[i]    <= 1'b0;
                    in_service[i] <= 1'b1;
                end else begin
                    if (wr_complete && (reg_wdata[4:0] == 5'(i))) begin
                        in_service[i] <= 1'b0;
                    end
                    if (src[i] && !pending[i] && !in_service[i] &&
                        (!edge_mode[i] || !prev_src[i])) begin
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_irq_controller.sv
// tb_ext_irq_controller
//   Directed scenarios with literal expectations, followed by randomized
//   register/source traffic checked every cycle against a mask-based
//   software model of the controller. Built without EXT_IRQ_SYNC_EN.
module tb_ext_irq_controller;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic          reg_we = 1'b0;
    logic          reg_re = 1'b0;
    logic [7:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          meip;
    logic [4:0]    best_id;

    ext_irq_controller #(
        .NUM_SOURCES(N),
        .PRIO_WIDTH (3),
        .ADDR_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .meip     (meip),
        .best_id  (best_id)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model. Bit positions in the 32-bit masks are source IDs.
    localparam bit [31:0] VALID = ((32'd1 << (N + 1)) - 1) & ~32'd1;

    int unsigned m_prio [1:N];
    int unsigned m_thr;
    bit [31:0]   m_en, m_edge, m_pend, m_isv, m_prev;
    bit [31:0]   m_rdata;
    bit          m_meip;
    int unsigned m_best;

    function automatic int unsigned m_winner();
        int unsigned top = 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && m_prio[id] > top)
                top = m_prio[id];
        if (top == 0) return 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] == top) return id;
        return 0;
    endfunction

    function automatic bit [31:0] m_read(input logic [7:0] a, input int unsigned w);
        if (a >= 1 && a <= N) return m_prio[a];
        case (a)
            8'h40:   return m_en;
            8'h41:   return m_pend;
            8'h42:   return m_thr;
            8'h43:   return w;
            8'h44:   return m_edge;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int unsigned w;
        bit [31:0]   src32, rise, claim_m, cmpl_m, new_req;
        int unsigned cid;
        if (!rst) begin
            for (int id = 1; id <= N; id++) m_prio[id] = 0;
            m_thr = 0; m_en = 0; m_edge = 0; m_pend = 0; m_isv = 0; m_prev = 0;
            m_rdata = 0; m_meip = 0; m_best = 0;
            return;
        end
        w = m_winner();
        src32 = 32'(irq_src) << 1;
        if (reg_re) m_rdata = m_read(reg_addr, w);
        claim_m = (reg_re && reg_addr == 8'h43 && w != 0) ? (32'd1 << w) : 32'd0;
        cid = reg_wdata[4:0];
        cmpl_m = (reg_we && reg_addr == 8'h43 && cid >= 1 && cid <= N && m_isv[cid])
                 ? (32'd1 << cid) : 32'd0;
        rise    = src32 & ~(m_edge & m_prev);
        new_req = rise & ~m_isv & ~claim_m & VALID;
        m_pend  = (m_pend | new_req) & ~claim_m;
        m_isv   = (m_isv | claim_m) & ~cmpl_m;
        if (reg_we) begin
            if (reg_addr >= 1 && reg_addr <= N) m_prio[reg_addr] = reg_wdata & 32'd7;
            if (reg_addr == 8'h40) m_en   = reg_wdata & VALID;
            if (reg_addr == 8'h42) m_thr  = reg_wdata & 32'd7;
            if (reg_addr == 8'h44) m_edge = reg_wdata & VALID;
        end
        m_prev = src32;
        m_best = w;
        m_meip = (w != 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rdata_model", reg_rdata, m_rdata);
        check("meip_model", meip, m_meip);
        check("best_id_model", best_id, m_best);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        reg_re = 1'b1; reg_addr = a;
        tick();
        reg_re = 1'b0;
        d = reg_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    logic [7:0] addr_tab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h08, 8'h09, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

    initial begin
        logic [31:0] d;

        // Reset with all sources high
        irq_src = '1;
        rst = 1'b0;
        repeat (3) tick();
        check("reset_rdata", reg_rdata, 32'd0);
        check("reset_meip", meip, 1'b0);
        check("reset_best_id", best_id, 5'd0);
        irq_src = '0;
        rst = 1'b1;
        reg_read(8'h41, d);
        check("reset_pending", d, 32'h0);

        // Priority / threshold
        do_reset();
        reg_write(8'h02, 32'd3);
        reg_write(8'h05, 32'd5);
        reg_write(8'h40, 32'h24);
        reg_write(8'h42, 32'd2);
        irq_src = 8'h12;
        tick();
        check("prio_meip_e0", meip, 1'b0);
        tick();
        check("prio_meip_e1", meip, 1'b1);
        check("prio_best_id", best_id, 5'd5);
        reg_write(8'h42, 32'd5);
        tick();
        check("thr_meip_masked", meip, 1'b0);
        check("thr_best_masked", best_id, 5'd0);

        // Tie on priority
        irq_src = '0;
        do_reset();
        reg_write(8'h03, 32'd4);
        reg_write(8'h06, 32'd4);
        reg_write(8'h40, 32'h48);
        irq_src = 8'h24;
        repeat (2) tick();
        reg_read(8'h43, d); check("tie_claim1", d, 32'd3);
        reg_read(8'h43, d); check("tie_claim2", d, 32'd6);
        reg_read(8'h43, d); check("tie_claim3", d, 32'd0);

        // Claim/complete on a level source
        irq_src = '0;
        do_reset();
        reg_write(8'h04, 32'd1);
        reg_write(8'h40, 32'h10);
        irq_src = 8'h08;
        repeat (2) tick();
        check("lvl_meip", meip, 1'b1);
        reg_read(8'h43, d); check("lvl_claim", d, 32'd4);
        reg_read(8'h41, d); check("lvl_pend_cleared", d, 32'h0);
        check("lvl_meip_dropped", meip, 1'b0);
        reg_write(8'h43, 32'd4);
        tick();
        reg_read(8'h41, d); check("lvl_repend", d, 32'h10);
        reg_write(8'h43, 32'd7);
        reg_read(8'h41, d); check("lvl_bad_complete", d, 32'h10);
        check("lvl_meip_again", meip, 1'b1);

        // Edge mode
        irq_src = '0;
        do_reset();
        reg_write(8'h44, 32'h2);
        reg_write(8'h01, 32'd2);
        reg_write(8'h40, 32'h2);
        irq_src = 8'h01; tick(); irq_src = '0;
        reg_read(8'h41, d); check("edge_pend", d, 32'h2);
        irq_src = 8'h01; tick(); irq_src = '0; tick();
        reg_read(8'h43, d); check("edge_claim1", d, 32'd1);
        reg_read(8'h43, d); check("edge_claim2", d, 32'd0);
        irq_src = 8'h01; tick(); irq_src = '0;
        reg_read(8'h41, d); check("edge_insvc_drop", d, 32'h0);

        // Claim while the level source is still high
        do_reset();
        reg_write(8'h02, 32'd1);
        reg_write(8'h40, 32'h4);
        irq_src = 8'h02;
        repeat (2) tick();
        reg_read(8'h43, d); check("sim_claim", d, 32'd2);
        repeat (2) tick();
        reg_read(8'h41, d); check("sim_pend_held", d, 32'h0);
        reg_write(8'h43, 32'd2);
        tick();
        reg_read(8'h41, d); check("sim_repend", d, 32'h4);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            reg_we    = ($urandom_range(0, 3) == 0);
            reg_re    = ($urandom_range(0, 2) == 0);
            reg_addr  = addr_tab[$urandom_range(0, 15)];
            reg_wdata = $urandom();
            if ($urandom_range(0, 1) == 1) reg_wdata = $urandom_range(0, 10);
            tick();
        end
        rst = 1'b1; reg_we = 1'b0; reg_re = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
